// File: rtl/vc_ram_1wnr_clr.sv
// Flip-flop RAM with one lane-masked write port and NUM_RD read ports, optional
// registered reads and write-to-read bypass, plus a clear sequencer run after reset.
module vc_ram_1wnr_clr #(
    parameter int DATA_SZ = 32,
    parameter int LANE_SZ = 8,
    parameter int ENTRIES = 16,
    parameter int ADDR_SZ = 4,
    parameter int NUM_RD = 2,
    parameter int SYNC_READ = 0,
    parameter int WR_BYPASS = 1,
    parameter logic [DATA_SZ-1:0] CLEAR_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         reset_p,
    input  logic [NUM_RD*ADDR_SZ-1:0]    raddr,
    output logic [NUM_RD*DATA_SZ-1:0]    rdata,
    input  logic                         wen_p,
    input  logic [ADDR_SZ-1:0]           waddr_p,
    input  logic [DATA_SZ/LANE_SZ-1:0]   wmask_p,
    input  logic [DATA_SZ-1:0]           wdata_p,
    input  logic                         clr_req,
    output logic                         busy,
    output logic                         wr_drop
);

    localparam int NLANE = DATA_SZ / LANE_SZ;
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);
    localparam logic [ADDR_SZ:0] ENTRIES_X = (ADDR_SZ + 1)'(ENTRIES);

    // busy is the externally visible copy of the FSM state.
    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_SZ-1:0] mem [ENTRIES];
    logic               wr_ok;
    logic               wr_drop_q;

    function automatic logic addr_ok(input logic [ADDR_SZ-1:0] a);
        return {1'b0, a} < ENTRIES_X;
    endfunction

    function automatic logic [DATA_SZ-1:0] merge(input logic [DATA_SZ-1:0] old_v,
                                                 input logic [DATA_SZ-1:0] new_v,
                                                 input logic [NLANE-1:0]   m);
        logic [DATA_SZ-1:0] r;
        r = old_v;
        for (int k = 0; k < NLANE; k++) begin
            if (m[k]) r[k*LANE_SZ +: LANE_SZ] = new_v[k*LANE_SZ +: LANE_SZ];
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_CLEAR: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q   <= ST_CLEAR;
            idx_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wr_drop_q <= wen_p && !wr_ok;
        end
    end

    assign busy    = (state_q == ST_CLEAR);
    assign wr_drop = wr_drop_q;
    assign wr_ok   = wen_p && !busy && addr_ok(waddr_p);

    // Storage carries no reset; the clear sequence is what initialises it.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem[idx_q] <= CLEAR_VALUE;
        end else if (wr_ok) begin
            mem[waddr_p[IDX_W-1:0]] <= merge(mem[waddr_p[IDX_W-1:0]], wdata_p, wmask_p);
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_SZ-1:0] a;
        logic [DATA_SZ-1:0] val;

        assign a = raddr[i*ADDR_SZ +: ADDR_SZ];

        always_comb begin
            val = CLEAR_VALUE;
            if (!busy && addr_ok(a)) begin
                val = mem[a[IDX_W-1:0]];
                if (WR_BYPASS != 0 && wr_ok && waddr_p == a) begin
                    val = merge(val, wdata_p, wmask_p);
                end
            end
        end

        if (SYNC_READ != 0) begin : g_sync
            logic [DATA_SZ-1:0] q;
            always_ff @(posedge clk or posedge reset_p) begin
                if (reset_p) q <= CLEAR_VALUE;
                else         q <= val;
            end
            assign rdata[i*DATA_SZ +: DATA_SZ] = q;
        end else begin : g_comb
            assign rdata[i*DATA_SZ +: DATA_SZ] = val;
        end
    end

endmodule
